shift_pipe_arbiter: RTL and testbench

//   Shares one serial shift pipeline (the 2-stage serial-in shift datapath, input a, output b)

---
 rtl/shift_pipe_arbiter.sv | 124 ++++++++++++
 tb/tb_shift_pipe_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe_arbiter.sv
// Round-robin front end that lets NUM_REQ requesters share one serial shift pipeline.
// Each granted word is sent MSB-first, then the pipeline is allowed to drain before the next grant.
module shift_pipe_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int WIDTH      = 8,
  parameter  int PIPE_DEPTH = 2,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       ser_out,
  output logic                       ser_en,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy,
  output logic                       done
);

  localparam int CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FC_W    = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam int FC_INIT = (PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FLUSH
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] shreg_q,     shreg_d;
  logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [ID_W-1:0]  grant_id_q,  grant_id_d;
  logic [ID_W-1:0]  last_q,      last_d;

  logic win_found;
  int   win_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      flush_cnt_q <= '0;
      grant_id_q  <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      grant_id_q  <= grant_id_d;
      last_q      <= last_d;
    end
  end

  // Round-robin search starts one past the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    flush_cnt_d = flush_cnt_q;
    grant_id_d  = grant_id_q;
    last_d      = last_q;
    req_ready   = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          shreg_d    = req_data[win_idx*WIDTH +: WIDTH];
          grant_id_d = ID_W'(win_idx);
          last_d     = ID_W'(win_idx);
          bit_cnt_d  = CNT_W'(WIDTH - 1);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_q << 1;
        if (bit_cnt_q == '0) begin
          if (PIPE_DEPTH == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_FLUSH;
            flush_cnt_d = FC_W'(FC_INIT);
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered-state decode only, so reset clears these outputs without waiting for a clock.
  assign ser_en   = (state_q == S_SHIFT);
  assign ser_out  = ser_en & shreg_q[WIDTH-1];
  assign busy     = (state_q != S_IDLE);
  assign grant_id = grant_id_q;
  assign done     = (PIPE_DEPTH == 0) ? ((state_q == S_SHIFT) && (bit_cnt_q == '0))
                                      : ((state_q == S_FLUSH) && (flush_cnt_q == '0));

endmodule

// File: tb/tb_shift_pipe_arbiter.sv
// Directed bench for shift_pipe_arbiter with NUM_REQ=4, WIDTH=8, PIPE_DEPTH=2.
// A two-flop model of the downstream shift datapath checks when bits reach its output.
module tb_shift_pipe_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        ser_out;
  logic        ser_en;
  logic [1:0]  grant_id;
  logic        busy;
  logic        done;

  logic [1:0]  pipe = 2'b00;
  int          n_cmp = 0;
  int          n_err = 0;

  shift_pipe_arbiter #(
    .NUM_REQ   (4),
    .WIDTH     (8),
    .PIPE_DEPTH(2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .ser_out  (ser_out),
    .ser_en   (ser_en),
    .grant_id (grant_id),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) pipe <= {pipe[0], ser_out};

  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the accept cycle T; returns in cycle T+11 with the arbiter idle.
  task automatic frame(input logic [7:0] w, input logic [1:0] id,
                       input logic [3:0] va, input logic [3:0] vl);
    tick();
    req_valid = va;
    req_data  = ~req_data;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      chk("shift_ser_en", ser_en, 1);
      chk("shift_ser_out", ser_out, w[7-i]);
      chk("shift_busy", busy, 1);
      chk("shift_done", done, 0);
      chk("shift_ready_blocked", req_ready, 0);
      if (i == 0) chk("shift_grant_id", grant_id, id);
      if (i >= 2) chk("datapath_b1", pipe[1], w[9-i]);
    end
    req_valid = vl;
    tick();
    chk("flush1_ser_en", ser_en, 0);
    chk("flush1_ser_out", ser_out, 0);
    chk("flush1_busy", busy, 1);
    chk("flush1_done", done, 0);
    chk("flush1_b1", pipe[1], w[1]);
    tick();
    chk("flush2_done", done, 1);
    chk("flush2_busy", busy, 1);
    chk("flush2_ser_en", ser_en, 0);
    chk("flush2_grant_id", grant_id, id);
    chk("flush2_b1", pipe[1], w[0]);
    tick();
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    repeat (2) tick();
    chk("rst_ser_en", ser_en, 0);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_ready", req_ready, 0);

    // Sole requester 0 after release
    reset     = 1'b0;
    req_valid = 4'b0001;
    req_data  = 32'h0000_003C;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    frame(8'h3C, 2'd0, 4'b0000, 4'b0000);

    // Requester 1 with A5
    req_data  = 32'h0000_A500;
    req_valid = 4'b0010;
    #1;
    chk("t2_ready", req_ready, 4'b0010);
    frame(8'hA5, 2'd1, 4'b0000, 4'b0000);
    tick();
    chk("t2_grant_hold", grant_id, 1);
    chk("t2_idle_ready", req_ready, 0);

    // Reset pulse in IDLE puts the pointer back to 3
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_pulse_grant_id", grant_id, 0);

    // All four requesting: 0,1,2,3,0 at 11-cycle spacing
    req_data  = 32'h96C3_2211;
    req_valid = 4'b1111;
    #1;
    chk("t3_ready0", req_ready, 4'b0001);
    frame(8'h11, 2'd0, 4'b1111, 4'b1111);
    req_data = 32'h96C3_2211;
    #1;
    chk("t3_ready1", req_ready, 4'b0010);
    frame(8'h22, 2'd1, 4'b1111, 4'b1111);
    req_data = 32'h96C3_2211;
    #1;
    chk("t3_ready2", req_ready, 4'b0100);
    frame(8'hC3, 2'd2, 4'b1111, 4'b1111);
    req_data = 32'h96C3_2211;
    #1;
    chk("t3_ready3", req_ready, 4'b1000);
    frame(8'h96, 2'd3, 4'b1111, 4'b1111);
    req_data = 32'h96C3_2211;
    #1;
    chk("t3_ready0_again", req_ready, 4'b0001);
    frame(8'h11, 2'd0, 4'b0100, 4'b0100);
    req_data = 32'h96C3_2211;
    #1;
    chk("t3_ready2_only", req_ready, 4'b0100);
    frame(8'hC3, 2'd2, 4'b1010, 4'b1010);

    // last=2 with 1010: 3 then 1
    req_data = 32'h96C3_2211;
    #1;
    chk("t4_ready3", req_ready, 4'b1000);
    frame(8'h96, 2'd3, 4'b1010, 4'b1010);
    req_data = 32'h96C3_2211;
    #1;
    chk("t4_ready1", req_ready, 4'b0010);
    frame(8'h22, 2'd1, 4'b0100, 4'b0100);

    // Reset during the fourth serial bit
    req_data = 32'h96C3_2211;
    #1;
    chk("t5_ready2", req_ready, 4'b0100);
    tick();
    repeat (3) tick();
    chk("t5_pre_ser_en", ser_en, 1);
    chk("t5_pre_grant_id", grant_id, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_ser_en", ser_en, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_done", done, 0);
    chk("t5_async_ser_out", ser_out, 0);
    chk("t5_async_grant_id", grant_id, 0);
    req_valid = 4'b0000;
    tick();
    chk("t5_in_rst_done", done, 0);
    reset = 1'b0;
    #1;
    req_valid = 4'b1111;
    #1;
    chk("t5_ptr_back_to_3", req_ready, 4'b0001);
    req_valid = 4'b0000;
    tick();
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_done", done, 0);

    // Requester 2 drops its request before the frame completes
    req_data  = 32'h0000_005A;
    req_valid = 4'b0001;
    #1;
    chk("t6_ready0", req_ready, 4'b0001);
    frame(8'h5A, 2'd0, 4'b0100, 4'b0000);
    chk("t6_no_ready", req_ready, 0);
    tick();
    chk("t6_stay_idle", busy, 0);
    chk("t6_no_ready_later", req_ready, 0);
    chk("t6_ser_en", ser_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
